// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
//
// Contents:
//   state_e       - run-control FSM states (idle, running, finishing last period)
//   MIN_DIV       - smallest divisor the counter can honour
//   clamp_div     - raises an out-of-range divisor to MIN_DIV
//   div_too_small - flags a divisor that needed clamping
package clk_div_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } state_e;

  // A divided clock needs at least one high and one low source cycle.
  localparam int unsigned MIN_DIV = 2;

  function automatic int unsigned clamp_div(input int unsigned val);
    return (val < MIN_DIV) ? MIN_DIV : val;
  endfunction

  function automatic logic div_too_small(input int unsigned val);
    return val < MIN_DIV;
  endfunction

endpackage

// File: rtl/clk_div_cnt.sv
// Period counter for the clock divider.
//
// Counts 0..N-1 while the generator is active and produces registered clk_out and tick values
// for the state the generator will be in after the current edge.
//
// Ports:
//   clk_i       source clock
//   rst_ni      asynchronous active-low reset
//   cnt_en_i    generator is active this cycle (counter advances from its current value)
//   run_i       generator will be active after this edge (counter and outputs live)
//   div_i       divisor in force this cycle
//   div_next_i  divisor in force after this edge
//   wrap_o      counter is at the last cycle of the period (cnt == div_i - 1)
//   clk_out_o   registered divided clock
//   tick_o      registered last-cycle-of-period strobe
module clk_div_cnt
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cnt_en_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] div_i,
  input  logic [CNT_W-1:0] div_next_i,
  output logic             wrap_o,
  output logic             clk_out_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] last_cnt;
  logic [CNT_W-1:0] next_last_cnt;
  logic [CNT_W-1:0] next_half;

  assign last_cnt      = div_i - CNT_W'(1);
  assign next_last_cnt = div_next_i - CNT_W'(1);
  assign next_half     = div_next_i >> 1;
  assign wrap_o        = (cnt_q == last_cnt);

  always_comb begin
    cnt_d     = '0;
    clk_out_d = 1'b0;
    tick_d    = 1'b0;
    // Entering the running states starts a fresh period at zero; leaving them parks at zero.
    if (run_i && cnt_en_i && !wrap_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (run_i) begin
      // Outputs are computed against the divisor that will be active, so a divisor change
      // at the wrap takes effect from the very first cycle of the new period.
      clk_out_d = (cnt_d < next_half);
      tick_d    = (cnt_d == next_last_cnt);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out_o = clk_out_q;
  assign tick_o    = tick_q;

endmodule

// File: rtl/clk_div_gen.sv
// Programmable glitch-free clock divider with period strobe.
//
// Derives clk_out (period N source cycles, N/2 high then N-N/2 low) and a one-cycle tick on the
// last cycle of each period. A newly loaded divisor is held pending and applied only at a period
// boundary (or immediately while idle), so clk_out never produces a short pulse.
//
// Optional feature: define CLK_DIV_STATS_EN to add period_cnt, a saturating count of completed
// divided periods that clears whenever the generator returns to idle.
//
// Ports:
//   clk         source clock
//   rst_n       asynchronous active-low reset
//   en          run request (level)
//   div_val     new divisor, captured when div_load is high
//   div_load    load request for div_val
//   div_ack     one-cycle pulse when the pending divisor becomes active
//   clk_out     divided clock
//   tick        high for the last source cycle of each divided period
//   busy        generator running or finishing its last period
//   div_err     sticky flag: a divisor below 2 was loaded and clamped
//   period_cnt  (CLK_DIV_STATS_EN only) completed divided periods
module clk_div_gen
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             div_ack,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             div_err
`ifdef CLK_DIV_STATS_EN
  ,
  output logic [31:0]      period_cnt
`endif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_ack_q, div_ack_d;
  logic             busy_q, busy_d;
  logic             div_err_q, div_err_d;

  logic             wrap;
  logic             active_now;
  logic             active_next;
  logic             apply;
  logic [CNT_W-1:0] load_val;
  logic             load_bad;

  assign active_now  = (state_q != StIdle);
  assign active_next = (state_d != StIdle);

  // Run-control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (en) state_d = StRun;
      end
      StRun: begin
        if (!en) state_d = StStopping;
      end
      StStopping: begin
        if (en) begin
          state_d = StRun;
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign load_val = CNT_W'(clamp_div(32'(div_val)));
  assign load_bad = div_too_small(32'(div_val));

  // Divisor handling. A load sampled on the wrap edge lands in pend_q on that same edge and is
  // therefore only seen by the following wrap.
  always_comb begin
    apply      = pend_vld_q && (!active_now || wrap);
    div_d      = apply ? pend_q : div_q;
    div_ack_d  = apply;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (div_load) begin
      // Last load wins; only one ack is issued when the survivor is applied.
      pend_d     = load_val;
      pend_vld_d = 1'b1;
    end else if (apply) begin
      pend_vld_d = 1'b0;
    end
    div_err_d = div_err_q | (div_load & load_bad);
    busy_d    = active_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_q      <= CNT_W'(DEF_DIV);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      div_ack_q  <= 1'b0;
      busy_q     <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      div_ack_q  <= div_ack_d;
      busy_q     <= busy_d;
      div_err_q  <= div_err_d;
    end
  end

  clk_div_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cnt_en_i   (active_now),
    .run_i      (active_next),
    .div_i      (div_q),
    .div_next_i (div_d),
    .wrap_o     (wrap),
    .clk_out_o  (clk_out),
    .tick_o     (tick)
  );

  assign div_ack = div_ack_q;
  assign busy    = busy_q;
  assign div_err = div_err_q;

`ifdef CLK_DIV_STATS_EN
  logic [31:0] period_cnt_q, period_cnt_d;

  // A period completes on its wrap edge; returning to idle clears the count.
  always_comb begin
    period_cnt_d = period_cnt_q;
    if (active_now && !active_next) begin
      period_cnt_d = '0;
    end else if (active_now && wrap && (period_cnt_q != 32'hFFFF_FFFF)) begin
      period_cnt_d = period_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_q <= '0;
    end else begin
      period_cnt_q <= period_cnt_d;
    end
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule
